// File: rtl/apb_timer_bank.sv
// apb_timer_bank: N independent prescaled compare timers behind one zero-wait-state APB slave
module apb_timer_bank #(
    parameter int N_TIMERS = 4,
    parameter int CNT_W    = 32,
    parameter int PRESC_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [11:0]         paddr_i,
    input  logic [31:0]         pwdata_i,
    input  logic                pwrite_i,
    input  logic                psel_i,
    input  logic                penable_i,
    output logic [31:0]         prdata_o,
    output logic                pready_o,
    output logic                pslverr_o,
    output logic [N_TIMERS-1:0] irq_o
);

    logic [2:0]          ctrl_q  [N_TIMERS];
    logic [2:0]          ctrl_d  [N_TIMERS];
    logic [PRESC_W-1:0]  presc_q [N_TIMERS];
    logic [PRESC_W-1:0]  presc_d [N_TIMERS];
    logic [PRESC_W-1:0]  pre_q   [N_TIMERS];
    logic [PRESC_W-1:0]  pre_d   [N_TIMERS];
    logic [CNT_W-1:0]    cmp_q   [N_TIMERS];
    logic [CNT_W-1:0]    cmp_d   [N_TIMERS];
    logic [CNT_W-1:0]    cnt_q   [N_TIMERS];
    logic [CNT_W-1:0]    cnt_d   [N_TIMERS];
    logic [N_TIMERS-1:0] pend_q, pend_d;
    logic [N_TIMERS-1:0] ctrl_we, presc_we, cmp_we, cnt_we, tick, fire;
    logic                access, wr, ch_hit, pend_hit;
    logic [3:0]          ch_sel;
    logic [1:0]          off;
    logic                unused_bits;

    assign unused_bits = ^{paddr_i[1:0], pwdata_i};

    // APB address decode and handshake; every access completes in one cycle
    always_comb begin
        access    = psel_i & penable_i;
        wr        = access & pwrite_i;
        ch_sel    = paddr_i[7:4];
        off       = paddr_i[3:2];
        ch_hit    = (paddr_i[11:8] == 4'h0) && (int'(ch_sel) < N_TIMERS);
        pend_hit  = paddr_i[11:2] == 10'h040;
        pready_o  = access;
        pslverr_o = access & ~(ch_hit | pend_hit);
    end

    // Per-channel prescaler/counter next state; software writes override hardware updates
    always_comb begin
        ctrl_we  = '0;
        presc_we = '0;
        cmp_we   = '0;
        cnt_we   = '0;
        tick     = '0;
        fire     = '0;
        irq_o    = '0;
        ctrl_d   = ctrl_q;
        presc_d  = presc_q;
        pre_d    = pre_q;
        cmp_d    = cmp_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < N_TIMERS; i++) begin
            ctrl_we[i]  = wr && ch_hit && ch_sel == 4'(i) && off == 2'd0;
            presc_we[i] = wr && ch_hit && ch_sel == 4'(i) && off == 2'd1;
            cmp_we[i]   = wr && ch_hit && ch_sel == 4'(i) && off == 2'd2;
            cnt_we[i]   = wr && ch_hit && ch_sel == 4'(i) && off == 2'd3;
            tick[i]     = ctrl_q[i][0] && pre_q[i] == presc_q[i];
            fire[i]     = tick[i] && !cnt_we[i] && cnt_q[i] == cmp_q[i];
            pre_d[i]    = (ctrl_we[i] && pwdata_i[0] && !ctrl_q[i][0]) || tick[i] ? '0 : pre_q[i] + PRESC_W'(ctrl_q[i][0]);
            cnt_d[i]    = cnt_we[i] ? pwdata_i[CNT_W-1:0] : fire[i] ? '0 : cnt_q[i] + CNT_W'(tick[i]);
            ctrl_d[i]   = ctrl_we[i] ? pwdata_i[2:0] : fire[i] && ctrl_q[i][1] ? {ctrl_q[i][2:1], 1'b0} : ctrl_q[i];
            presc_d[i]  = presc_we[i] ? pwdata_i[PRESC_W-1:0] : presc_q[i];
            cmp_d[i]    = cmp_we[i] ? pwdata_i[CNT_W-1:0] : cmp_q[i];
            irq_o[i]    = pend_q[i] & ctrl_q[i][2];
        end
        pend_d = (pend_q & ~(wr && pend_hit ? pwdata_i[N_TIMERS-1:0] : '0)) | fire;
    end

    // Read mux, driven only during a valid access phase
    always_comb begin
        prdata_o = '0;
        if (access && pend_hit)
            prdata_o = 32'(pend_q);
        for (int i = 0; i < N_TIMERS; i++)
            if (access && ch_hit && ch_sel == 4'(i))
                prdata_o = off == 2'd0 ? 32'(ctrl_q[i]) : off == 2'd1 ? 32'(presc_q[i]) : off == 2'd2 ? 32'(cmp_q[i]) : 32'(cnt_q[i]);
    end

    // State registers with synchronous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_TIMERS; i++) begin
                ctrl_q[i]  <= '0;
                presc_q[i] <= '0;
                pre_q[i]   <= '0;
                cmp_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
            pend_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            pre_q   <= pre_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: doc/apb_timer_bank.md
Name: apb_timer_bank

Overview:
- Parametrised successor to the single fixed timer on the peripheral APB segment.
- Provides N_TIMERS independent channels. Each channel has its own prescaler, counter width CNT_W, compare value, periodic or one-shot mode, and a maskable interrupt.
- Sits behind the APB bar as one slave; per-channel irq_o bits go to the core interrupt inputs.

Parameters:
- N_TIMERS, 4, number of channels; legal range 1..8.
- CNT_W, 32, counter and compare width; legal range 8..32.
- PRESC_W, 16, prescaler width; legal range 1..16.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- paddr_i  in  12  APB byte address; bits [1:0] are ignored
- pwdata_i  in  32  APB write data
- pwrite_i  in  1  APB write strobe; 1 = write
- psel_i  in  1  APB slave select
- penable_i  in  1  APB access phase
- prdata_o  out  32  APB read data
- pready_o  out  1  APB ready
- pslverr_o  out  1  APB error response
- irq_o  out  N_TIMERS  per-channel interrupt, level-sensitive

Behaviour:
- Reset: one clock and synchronous active-high reset (rst_i); every register clears on the rising edge of clk_i while rst_i=1.
  - Cleared state: CTRL=0, PRESC=0, CMP=0, CNT=0, prescaler counters=0, PEND=0.
  - Outputs: irq_o=0, prdata_o=0, pready_o=0, pslverr_o=0.
  - Reset mid-operation aborts counting and drops pending interrupts in the same edge.
- Register map; channel i base = i*0x10:
  - +0x0 CTRL: bit0 EN, bit1 ONESHOT, bit2 IRQ_EN.
  - +0x4 PRESC: PRESC_W bits.
  - +0x8 CMP: CNT_W bits.
  - +0xC CNT: CNT_W bits, read/write.
  - 0x100 PEND: N_TIMERS bits; read returns pending bits, writing 1 clears a bit.
  - Unwritten upper bits read 0.
- APB access:
  - Setup phase (psel_i=1, penable_i=0): no action.
  - Access phase (psel_i=1, penable_i=1): pready_o=1 combinationally; zero wait states.
  - Writes commit on the access-phase clock edge.
  - prdata_o is combinational from the current register state during the access phase and 0 otherwise.
  - Unmapped address (channel index >= N_TIMERS, or offset not listed): pslverr_o=1 with pready_o=1, write ignored, prdata_o=0.
  - Outside the access phase, pready_o=0 and pslverr_o=0.
- Prescaler, per channel, while EN=1:
  - pre counts 0..PRESC, then wraps to 0.
  - tick = (pre==PRESC). PRESC=0 gives a tick every cycle; PRESC=N gives a tick every N+1 cycles.
- Counter, on a tick:
  - If CNT==CMP: set PEND[i]; CNT<=0.
    - ONESHOT=1: EN<=0 in the same edge. The counter then holds at 0 and no further ticks occur.
    - ONESHOT=0: counting continues from 0.
  - Otherwise CNT<=CNT+1, wrapping modulo 2^CNT_W.
  - CMP=0 fires on every tick.
  - CMP written below the current CNT: the counter wraps through 2^CNT_W before matching.
- EN=0: pre and CNT hold their values; no ticks. A write that sets EN from 0 to 1 clears pre to 0; CNT is kept.
- Simultaneous events:
  - Software write to CNT in the same cycle as a tick: the software value wins; no compare is evaluated that cycle.
  - PEND write-1-to-clear in the same cycle as a hardware set of the same bit: the set wins; PEND stays 1.
  - Software write to CTRL in the same cycle as a one-shot auto-clear of EN: the software value wins.
- irq_o[i] = PEND[i] & IRQ_EN[i], registered-free. Clearing IRQ_EN masks irq_o without clearing PEND.
- Latency:
  - irq_o rises on the clock edge at which the matching tick is processed.
  - With PRESC=0, CMP=K and EN set at edge 0, irq_o rises at edge K+1.

Test Plan:
- Reset with N_TIMERS=4: read all 16 channel registers and PEND -> all read 0; irq_o=0; pslverr_o=0 on every read.
- Ch0 periodic, PRESC=0, CMP=3, IRQ_EN=1, EN=1:
  - irq_o[0] rises 4 cycles after the enabling write.
  - Write PEND=0x1 -> irq_o[0] falls on the next edge.
  - irq_o[0] rises again 4 cycles after the previous rise.
- Ch1 one-shot, PRESC=2, CMP=1:
  - PEND[1] sets 6 cycles after enable.
  - CTRL[0] then reads 0 and CNT reads 0 for the following 20 cycles.
- Ch2 with CNT_W=8, PRESC=0, CMP=5, CNT written to 0x10 -> counter wraps 0xFF->0x00; PEND[2] sets after 246 ticks.
- Corner cases:
  - Write PEND=0x4 in the same cycle ch2 fires -> PEND[2] reads 1.
  - Write CNT=0 coincident with a tick -> CNT reads 0 and PEND is unchanged.
- Access to address 0x040 with N_TIMERS=4 -> pslverr_o=1, pready_o=1, prdata_o=0, no register changes.
- Assert rst_i for 1 cycle while ch3 is counting -> next cycle all registers are 0 and irq_o=0.
